// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Provides the receive FSM state type, framing constants and a divider clamp helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   localparam int MIN_DIV   = 4;
   localparam int DATA_BITS = 8;

   // Dividers below MIN_DIV leave no room for a mid-bit sample point.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d < 16'(MIN_DIV)) ? 16'(MIN_DIV) : d;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO with a registered head output.
// Ports: clock, resetb (async low), push/wdata, pop, rdata (head), full, empty.
module uart_rx_fifo
#(
   parameter int DEPTH = 4
) (
   input  logic       clock,
   input  logic       resetb,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW-1:0] rp_nxt;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop frees the slot in the same cycle, so a full FIFO can still accept.
   assign do_push = push & (~full | do_pop);
   assign rp_nxt  = do_pop ? rp + AW'(1) : rp;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         wp    <= '0;
         rp    <= '0;
         cnt   <= '0;
         rdata <= '0;
      end else begin
         if (do_push)
            wp <= wp + AW'(1);
         rp  <= rp_nxt;
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
         // Head register: bypass the write when the new byte becomes the head.
         if (do_push | do_pop)
            rdata <= (do_push && rp_nxt == wp) ? wdata : mem[rp_nxt];
      end
   end

   always_ff @(posedge clock) begin
      if (do_push)
         mem[wp] <= wdata;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) with FIFO, sticky errors, irq.
// Ports: clock, resetb, rx, clk_div, rx_data/rx_valid/rx_ready pop port, frame_err, parity_err, overrun, err_clear, irq.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        resetb,
   input  logic        rx,
   input  logic [15:0] clk_div,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        frame_err,
   output logic        parity_err,
   output logic        overrun,
   input  logic        err_clear,
   output logic        irq
);

   rx_state_t   state;
   logic        rx_s1;
   logic        rxs;
   logic        rxs_d;
   logic [15:0] div_in;
   logic [15:0] div_q;
   logic [15:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        par_bad;
   logic        push_q;
   logic        ferr_q;
   logic        ovr;
   logic        full;
   logic        empty;
   logic        tick;
   logic        fall;
`ifdef UART_RX_PARITY_EN
   logic        perr_q;
`endif

   assign div_in = eff_div(clk_div);
   assign tick   = (cnt == '0);
   assign fall   = rxs_d & ~rxs;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         rx_s1 <= 1'b1;
         rxs   <= 1'b1;
         rxs_d <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rxs   <= rx_s1;
         rxs_d <= rxs;
      end
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state   <= IDLE;
         div_q   <= 16'(MIN_DIV);
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         par_bad <= 1'b0;
         push_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         push_q <= 1'b0;
         ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q <= 1'b0;
`endif
         if (!tick)
            cnt <= cnt - 16'd1;
         unique case (state)
            IDLE: begin
               if (fall) begin
                  div_q <= div_in;
                  cnt   <= (div_in >> 1) - 16'd1;
                  state <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (rxs) begin
                     state <= IDLE;
                  end else begin
                     cnt     <= div_q - 16'd1;
                     bit_idx <= '0;
                     par_bad <= 1'b0;
                     state   <= DATA;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  shreg   <= {rxs, shreg[7:1]};
                  cnt     <= div_q - 16'd1;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  par_bad <= rxs ^ (^shreg);
                  cnt     <= div_q - 16'd1;
                  state   <= STOP;
               end
            end
`endif
            STOP: begin
               // Outcome is registered; FIFO and flags act one clock later.
               if (tick) begin
                  state  <= IDLE;
                  ferr_q <= ~rxs;
                  push_q <= rxs & ~par_bad;
`ifdef UART_RX_PARITY_EN
                  perr_q <= rxs & par_bad;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Full with a simultaneous pop still accepts, so only a non-popping full drops.
   assign ovr = push_q & full & ~rx_ready;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr_q | (frame_err & ~err_clear);
         overrun   <= ovr | (overrun & ~err_clear);
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb)
         parity_err <= 1'b0;
      else
         parity_err <= perr_q | (parity_err & ~err_clear);
   end
`else
   assign parity_err = 1'b0;
`endif

   uart_rx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock  (clock),
      .resetb (resetb),
      .push   (push_q),
      .wdata  (shreg),
      .pop    (rx_ready),
      .rdata  (rx_data),
      .full   (full),
      .empty  (empty)
   );

   assign rx_valid = ~empty;
   assign irq      = rx_valid | frame_err | parity_err | overrun;

endmodule
